// File: rtl/field_packer_pkg.sv
// -----------------------------------------------------------------------------
// field_packer_pkg
// Shared declarations for the field_packer block.
//   state_t   : packer FSM state (ST_RUN accepts fields, ST_FLUSH emits a
//               trailing residual word)
//   widths_ok : elaboration-time sanity check of the IN_W/OUT_W pairing
// -----------------------------------------------------------------------------
package field_packer_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // A field must fit in one word, and a word must hold at least two bits
    function automatic bit widths_ok(input int in_w, input int out_w);
        return (in_w >= 1) && (in_w <= out_w) && (out_w >= 2);
    endfunction

endpackage

// File: rtl/field_packer_if.sv
// -----------------------------------------------------------------------------
// field_packer_if
// Field-in / word-out stream bundle for field_packer.
//   in_valid/in_ready   : field handshake
//   in_data [IN_W]      : right-aligned field
//   in_len  [LEN_W]     : field length 0..IN_W (larger values clamp to IN_W)
//   in_last             : flush after this field
//   out_valid/out_ready : word handshake
//   out_data [OUT_W]    : packed word, unused bits zero
//   out_bits [BITS_W]   : meaningful bits in out_data
//   out_last            : final word of a flushed packet
// Modports: master = field source / word sink, slave = the packer.
// -----------------------------------------------------------------------------
interface field_packer_if #(
    parameter int OUT_W  = 16,
    parameter int IN_W   = 8,
    parameter int LEN_W  = $clog2(IN_W + 1),
    parameter int BITS_W = $clog2(OUT_W + 1)
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic [LEN_W-1:0]  in_len;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [BITS_W-1:0] out_bits;
    logic              out_last;

    modport master (
        output in_valid, in_data, in_len, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_bits, out_last
    );

    modport slave (
        input  in_valid, in_data, in_len, in_last, out_ready,
        output in_ready, out_valid, out_data, out_bits, out_last
    );
endinterface

// File: rtl/field_packer_merge.sv
// -----------------------------------------------------------------------------
// field_packer_merge
// Purely combinational: appends one field to the accumulator.
//   acc     in  OUT_W   accumulated bits (zero outside the valid cnt bits)
//   cnt     in  BITS_W  valid bits in acc, 0..OUT_W-1
//   data    in  IN_W    right-aligned field
//   len     in  LEN_W   field length (clamped to IN_W here)
//   word    out OUT_W   full-word candidate, or acc+field when no spill
//   resid   out OUT_W   bits left over after a full word
//   new_cnt out BITS_W  residual count on spill, cnt+len otherwise
//   spill   out 1       cnt+len reached OUT_W
// Order: MSB-first by default; FIELD_PACKER_LSB_FIRST_EN selects LSB-first
// (first field in the LSBs, residual right-aligned).
// -----------------------------------------------------------------------------
module field_packer_merge #(
    parameter int OUT_W  = 16,
    parameter int IN_W   = 8,
    parameter int LEN_W  = $clog2(IN_W + 1),
    parameter int BITS_W = $clog2(OUT_W + 1)
) (
    input  logic [OUT_W-1:0]  acc,
    input  logic [BITS_W-1:0] cnt,
    input  logic [IN_W-1:0]   data,
    input  logic [LEN_W-1:0]  len,
    output logic [OUT_W-1:0]  word,
    output logic [OUT_W-1:0]  resid,
    output logic [BITS_W-1:0] new_cnt,
    output logic              spill
);
    localparam int WW = 2 * OUT_W;
    // cnt+len can reach 2*OUT_W-1, one bit wider than a count
    localparam int TW = BITS_W + 1;

    logic [LEN_W-1:0] len_c;
    logic [IN_W-1:0]  field;
    logic [TW-1:0]    total;
    logic [WW-1:0]    wide;

    always_comb begin
        len_c = (len > LEN_W'(IN_W)) ? LEN_W'(IN_W) : len;
        field = '0;
        for (int i = 0; i < IN_W; i++) begin
            field[i] = data[i] && (LEN_W'(i) < len_c);
        end
        total = TW'(cnt) + TW'(len_c);
        spill = (total >= TW'(OUT_W));
`ifdef FIELD_PACKER_LSB_FIRST_EN
        // Field sits just above the cnt valid bits; overflow lands in the
        // upper half, already right-aligned for the next word
        wide  = {{OUT_W{1'b0}}, acc} | (WW'(field) << cnt);
        word  = wide[OUT_W-1:0];
        resid = wide[WW-1:OUT_W];
`else
        // Field sits just below the cnt valid bits; overflow lands at the
        // top of the lower half, already left-aligned for the next word.
        // A zero total shifts the (zero) field fully out, which is harmless.
        wide  = {acc, {OUT_W{1'b0}}} | (WW'(field) << (WW - int'(total)));
        word  = wide[WW-1:OUT_W];
        resid = wide[OUT_W-1:0];
`endif
        new_cnt = spill ? BITS_W'(total - TW'(OUT_W)) : BITS_W'(total);
    end

endmodule

// File: rtl/field_packer.sv
// -----------------------------------------------------------------------------
// field_packer
// Streaming bit-field packer: concatenates variable-length fields into
// OUT_W-bit words, with an explicit in_last flush for the trailing word.
//   clk    in  rising-edge clock
//   rst_n  in  synchronous active-low reset
//   bus    slave modport of field_packer_if (field in, word out)
// Optional build macro FIELD_PACKER_LSB_FIRST_EN: LSB-first packing order.
// Output is a single register stage (data_p1/vld_p1); in_ready depends
// combinationally on out_ready only.
// -----------------------------------------------------------------------------
module field_packer
    import field_packer_pkg::*;
#(
    parameter int OUT_W  = 16,
    parameter int IN_W   = 8,
    parameter int LEN_W  = $clog2(IN_W + 1),
    parameter int BITS_W = $clog2(OUT_W + 1)
) (
    input logic           clk,
    input logic           rst_n,
    field_packer_if.slave bus
);
    if (!widths_ok(IN_W, OUT_W)) begin : g_width_check
        $error("field_packer: requires IN_W <= OUT_W and OUT_W >= 2");
    end

    state_t            state, state_n;
    logic [OUT_W-1:0]  acc, acc_n;
    logic [BITS_W-1:0] cnt, cnt_n;
    logic [OUT_W-1:0]  data_p1, data_n;
    logic [BITS_W-1:0] bits_p1, bits_n;
    logic              last_p1, last_n;
    logic              vld_p1, vld_n;

    logic [OUT_W-1:0]  word, resid;
    logic [BITS_W-1:0] new_cnt;
    logic              spill;
    logic              ready, accept, reg_free;

    field_packer_merge #(
        .OUT_W (OUT_W),
        .IN_W  (IN_W),
        .LEN_W (LEN_W),
        .BITS_W(BITS_W)
    ) u_merge (
        .acc    (acc),
        .cnt    (cnt),
        .data   (bus.in_data),
        .len    (bus.in_len),
        .word   (word),
        .resid  (resid),
        .new_cnt(new_cnt),
        .spill  (spill)
    );

    // Output register can take a new word if empty or draining this cycle
    assign reg_free = !vld_p1 || bus.out_ready;
    assign ready    = rst_n && (state == ST_RUN) && reg_free;
    assign accept   = bus.in_valid && ready;

    assign bus.in_ready  = ready;
    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_bits  = bits_p1;
    assign bus.out_last  = last_p1;

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        vld_n   = vld_p1 && !bus.out_ready;
        data_n  = data_p1;
        bits_n  = bits_p1;
        last_n  = last_p1;
        case (state)
            ST_RUN: begin
                if (accept) begin
                    if (spill) begin
                        vld_n  = 1'b1;
                        data_n = word;
                        bits_n = BITS_W'(OUT_W);
                        last_n = bus.in_last && (new_cnt == '0);
                        acc_n  = resid;
                        cnt_n  = new_cnt;
                        if (bus.in_last && (new_cnt != '0)) begin
                            state_n = ST_FLUSH;
                        end
                    end else if (bus.in_last) begin
                        // Partial (possibly empty) final word keeps the
                        // packet boundary visible downstream
                        vld_n  = 1'b1;
                        data_n = word;
                        bits_n = new_cnt;
                        last_n = 1'b1;
                        acc_n  = '0;
                        cnt_n  = '0;
                    end else begin
                        acc_n = word;
                        cnt_n = new_cnt;
                    end
                end
            end
            ST_FLUSH: begin
                if (reg_free) begin
                    vld_n   = 1'b1;
                    data_n  = acc;
                    bits_n  = cnt;
                    last_n  = 1'b1;
                    acc_n   = '0;
                    cnt_n   = '0;
                    state_n = ST_RUN;
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

    // ---- stage p1: accumulator, FSM and output register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            acc     <= '0;
            cnt     <= '0;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            bits_p1 <= '0;
            last_p1 <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            cnt     <= cnt_n;
            vld_p1  <= vld_n;
            data_p1 <= data_n;
            bits_p1 <= bits_n;
            last_p1 <= last_n;
        end
    end

endmodule

// File: tb/tb_field_packer.sv
// -----------------------------------------------------------------------------
// tb_field_packer
// Self-checking bench for field_packer (OUT_W=16, IN_W=8). Expected words are
// queued as stimulus is driven; produced words are captured and compared per
// scenario. Honors FIELD_PACKER_LSB_FIRST_EN for the expected packing order.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_field_packer;
`ifdef FIELD_PACKER_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic [4:0]  bits;
        logic        last;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    field_packer_if #(.OUT_W(16), .IN_W(8)) bus ();

    field_packer #(.OUT_W(16), .IN_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    bit    rand_bp = 1'b0;
    word_t exp_q[$];
    word_t act_q[$];
    bit    bq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every word at the point it is consumed
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
            act_q.push_back({bus.out_data, bus.out_bits, bus.out_last});
    end

    function automatic word_t mk(input logic [15:0] d, input int b, input logic l);
        word_t w;
        w.data = d;
        w.bits = 5'(b);
        w.last = l;
        return w;
    endfunction

    // Bit-stream reference: bq holds bits in stream order
    function automatic word_t pack_bits(input int n);
        word_t w;
        w = '0;
        w.bits = 5'(n);
        for (int j = 0; j < n; j++) begin
            if (LSB) w.data[j] = bq[j];
            else     w.data[15-j] = bq[j];
        end
        return w;
    endfunction

    task automatic model_field(input logic [7:0] d, input int l, input logic last);
        int    len;
        bit    spilled;
        word_t w;
        spilled = 1'b0;
        len = (l > 8) ? 8 : l;
        for (int i = 0; i < len; i++) bq.push_back(LSB ? d[i] : d[len-1-i]);
        if (bq.size() >= 16) begin
            w = pack_bits(16);
            repeat (16) void'(bq.pop_front());
            w.last = last && (bq.size() == 0);
            exp_q.push_back(w);
            spilled = 1'b1;
        end
        if (last && bq.size() > 0) begin
            w = pack_bits(bq.size());
            w.last = 1'b1;
            bq.delete();
            exp_q.push_back(w);
        end else if (last && !spilled) begin
            exp_q.push_back(mk(16'h0000, 0, 1'b1));
        end
    endtask

    // Drive one field and hold it until accepted (called at posedge+1)
    task automatic send(input logic [7:0] d, input int l, input logic last);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_len   = 4'(l);
        bus.in_last  = last;
        forever begin
            if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                errors++;
                $display("FAIL send_timeout: field %h not accepted after %0d cycles, expected acceptance", d, n);
                break;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        int n;
        n = 0;
        ok = 1'b1;
        rand_bp = 1'b0;
        bus.out_ready = 1'b1;
        while (bus.out_valid === 1'b1 || act_q.size() < exp_q.size()) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                ok = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 8'hFF;
        bus.in_len = 4'd8;
        bus.in_last = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h, expected 0000", bus.out_data); end
        checks++; if (bus.out_bits !== 5'd0) begin errors++; $display("FAIL reset_out_bits: got %0d, expected 0", bus.out_bits); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b, expected 0", bus.out_last); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, expected 0", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b, expected 1", bus.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_msb_concat();
        word_t e, a;
        bit    ok;
        send(8'h01, 2, 1'b0);
        send(8'h03, 3, 1'b0);
        send(8'h0B, 4, 1'b1);
        exp_q.push_back(mk(LSB ? 16'h016D : 16'h5D80, 9, 1'b1));
        wait_drain(ok);
        checks++;
        if (!ok || act_q.size() != exp_q.size()) begin
            errors++; $display("FAIL concat_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL concat_word: got %h/%0d/%b, expected %h/%0d/%b", a.data, a.bits, a.last, e.data, e.bits, e.last); end
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_exact_fill();
        word_t e, a;
        bit    ok;
        send(8'hAB, 8, 1'b0);
        send(8'hCD, 8, 1'b0);
        exp_q.push_back(mk(LSB ? 16'hCDAB : 16'hABCD, 16, 1'b0));
        // An empty last field only yields an empty word if cnt went back to 0
        send(8'h00, 0, 1'b1);
        exp_q.push_back(mk(16'h0000, 0, 1'b1));
        wait_drain(ok);
        checks++;
        if (!ok || act_q.size() != exp_q.size()) begin
            errors++; $display("FAIL fill_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL fill_word: got %h/%0d/%b, expected %h/%0d/%b", a.data, a.bits, a.last, e.data, e.bits, e.last); end
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_spill_last();
        word_t e, a;
        bit    ok;
        send(8'hFF, 8, 1'b0);
        send(8'h0A, 4, 1'b0);
        send(8'h12, 8, 1'b1);
        exp_q.push_back(mk(LSB ? 16'h2AFF : 16'hFFA1, 16, 1'b0));
        exp_q.push_back(mk(LSB ? 16'h0001 : 16'h2000, 4, 1'b1));
        bus.in_valid = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL spill_flush_in_ready: got %b, expected 0", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok || act_q.size() != exp_q.size()) begin
            errors++; $display("FAIL spill_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL spill_word: got %h/%0d/%b, expected %h/%0d/%b", a.data, a.bits, a.last, e.data, e.bits, e.last); end
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_backpressure();
        word_t       e, a;
        bit          ok;
        logic [15:0] held, nxt;
        held = LSB ? 16'hCDAB : 16'hABCD;
        nxt  = LSB ? 16'h005A : 16'h5A00;
        bus.out_ready = 1'b0;
        send(8'hAB, 8, 1'b0);
        send(8'hCD, 8, 1'b0);
        exp_q.push_back(mk(held, 16, 1'b0));
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        bus.in_len   = 4'd8;
        bus.in_last  = 1'b1;
        exp_q.push_back(mk(nxt, 8, 1'b1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
                errors++; $display("FAIL bp_hold: got valid=%b data=%h, expected valid=1 data=%h", bus.out_valid, bus.out_data, held);
            end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, expected 0", bus.in_ready); end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got in_ready=%b, expected 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== nxt) begin
            errors++; $display("FAIL bp_no_bubble: got valid=%b data=%h, expected valid=1 data=%h", bus.out_valid, bus.out_data, nxt);
        end
        @(posedge clk); #1;
        wait_drain(ok);
        checks++;
        if (!ok || act_q.size() != exp_q.size()) begin
            errors++; $display("FAIL bp_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL bp_word: got %h/%0d/%b, expected %h/%0d/%b", a.data, a.bits, a.last, e.data, e.bits, e.last); end
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_reset_mid_packet();
        word_t e, a;
        bit    ok;
        send(8'h15, 5, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b, expected 0", bus.in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(8'h80, 8, 1'b1);
        exp_q.push_back(mk(LSB ? 16'h0080 : 16'h8000, 8, 1'b1));
        wait_drain(ok);
        checks++;
        if (!ok || act_q.size() != exp_q.size()) begin
            errors++; $display("FAIL midrst_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL midrst_word: got %h/%0d/%b, expected %h/%0d/%b", a.data, a.bits, a.last, e.data, e.bits, e.last); end
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_zero_len_clamp();
        word_t e, a;
        bit    ok;
        send(8'hAB, 8, 1'b0);
        send(8'hFF, 0, 1'b0);
        send(8'hCD, 8, 1'b0);
        send(8'hA5, 12, 1'b1);
        exp_q.push_back(mk(LSB ? 16'hCDAB : 16'hABCD, 16, 1'b0));
        exp_q.push_back(mk(LSB ? 16'h00A5 : 16'hA500, 8, 1'b1));
        wait_drain(ok);
        checks++;
        if (!ok || act_q.size() != exp_q.size()) begin
            errors++; $display("FAIL zero_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL zero_word: got %h/%0d/%b, expected %h/%0d/%b", a.data, a.bits, a.last, e.data, e.bits, e.last); end
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_back_to_back();
        word_t       e, a;
        bit          ok;
        int          c0, c1;
        logic [7:0]  d;
        bus.out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 20; i++) begin
            d = 8'(i * 17 + 3);
            model_field(d, 8, i == 19);
            send(d, 8, i == 19);
        end
        c1 = cyc;
        checks++; if (c1 - c0 != 20) begin errors++; $display("FAIL b2b_cycles: got %0d cycles for 20 fields, expected 20", c1 - c0); end
        wait_drain(ok);
        checks++;
        if (!ok || act_q.size() != exp_q.size()) begin
            errors++; $display("FAIL b2b_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL b2b_word: got %h/%0d/%b, expected %h/%0d/%b", a.data, a.bits, a.last, e.data, e.bits, e.last); end
        end
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_random_fields();
        word_t      e, a;
        bit         ok;
        logic [7:0] d;
        int         l;
        logic       last;
        rand_bp = 1'b1;
        for (int i = 0; i < 150; i++) begin
            d    = 8'($urandom);
            l    = $urandom_range(0, 11);
            last = (i == 149) || ($urandom_range(0, 5) == 0);
            model_field(d, l, last);
            send(d, l, last);
        end
        wait_drain(ok);
        checks++;
        if (!ok || act_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL rand_word: got %h/%0d/%b, expected %h/%0d/%b", a.data, a.bits, a.last, e.data, e.bits, e.last); end
        end
        exp_q.delete(); act_q.delete();
    endtask

    initial begin
        test_reset();
        test_msb_concat();
        test_exact_fill();
        test_spill_last();
        test_backpressure();
        test_reset_mid_packet();
        test_zero_len_clamp();
        test_back_to_back();
        test_random_fields();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
